mm_periph: RTL and testbench
============================

# mm_periph

Memory-mapped peripheral responder on the CPU's external data bus (any address with `addr[15:13] != 0`). It answers CPU loads combinationally in the same cycle and commits CPU stores on the clock edge. It owns the LED output register, a synchronized switch input, and 32-bit statistics counters. The counters are fed by the branch-prediction pulses (`inc_br_cnt`, `inc_hit_cnt`, `inc_mispr_cnt`) plus a free-running cycle counter, so software can measure predictor accuracy.

## Interface
- `BASE`, 16'hC000: base address of the register block; it must have nonzero `[15:13]`.
- `LED_W`, 10: LED register width.
- `SW_W`, 10: switch input width.

Reset is asynchronous and active-low. The block uses one clock.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `addr`  in  16  CPU data address, valid in the same cycle as `mm_re`/`mm_we`.
- `wdata`  in  16  CPU store data.
- `mm_re`  in  1  external read strobe.
- `mm_we`  in  1  external write strobe.
- `rdata`  out  16  read data, combinational from `addr`/`mm_re`.
- `inc_br_cnt`  in  1  a branch resolved this cycle.
- `inc_hit_cnt`  in  1  a BTB prediction was correct this cycle.
- `inc_mispr_cnt`  in  1  a misprediction occurred this cycle.
- `sw`  in  `SW_W`  asynchronous switch inputs.
- `ledr`  out  `LED_W`  LED drive, registered.

## Operation
Register map, by offset from `BASE`:
- +0 LEDR (RW): holds `[LED_W-1:0]`; upper bits read as 0.
- +1 SW (RO): 2-flop synchronized `sw`, zero-extended.
- +4/+5 BR_LO/BR_HI (RO).
- +6/+7 HIT_LO/HIT_HI (RO).
- +8/+9 MIS_LO/MIS_HI (RO).
- +A/+B CYC_LO/CYC_HI (RO).
- +C CTRL (RW):
  - Write with bit0=1: clears all four counters; bit0 is self-clearing.
  - Bit1 is FREEZE: when 1, all counters hold.
  - Reads return `{14'b0, FREEZE, 1'b0}`.
- All other addresses: reads return 16'h0000; writes are ignored.

Read behaviour:
- `rdata` is 16'h0000 whenever `mm_re` = 0.
- Writes to RO registers are ignored.

Counter behaviour:
- Counters are 32-bit and wrap from 2^32-1 to 0.
- BR, HIT and MIS each add 1 per cycle in which their `inc_*` input is high.
- CYC adds 1 every cycle.
- Simultaneous `inc_*` pulses are counted independently.

Coherent 32-bit reads:
- Each counter has a 16-bit shadow register.
- A read of xx_LO returns `counter[15:0]`; on the same clock edge the shadow loads `counter[31:16]`.
- A read of xx_HI returns the shadow, not the live upper half.
- Reading HI without a preceding LO read returns the last latched shadow. Shadows reset to 0.

Priority per counter on each edge: clear > freeze hold > increment.

## Timing
Reset values:
- `ledr` = 0.
- FREEZE = 0.
- All counters, shadows and synchronizer flops = 0.
- `rdata` = 0 while `mm_re` = 0.

Reads:
- Zero-latency: `rdata` is valid in the cycle `mm_re` is high. The CPU samples it at the end of that cycle.
- Counter reads return the value before that cycle's increment.

Writes:
- Take effect at the rising edge that ends the `mm_we` cycle.
- A write to LEDR is visible on `ledr` the next cycle.
- A CTRL clear in cycle n makes every counter read 0 in cycle n+1, even if `inc_*` was high in cycle n.

Stalls:
- `mm_re` held high for several cycles re-latches the shadow each cycle.
- The final cycle's LO and shadow are consistent.

SW latency: a change on `sw` appears in reads 2–3 cycles later.

Both strobes high in the same cycle: the write commits at the edge, and `rdata` reflects pre-write state.

Asynchronous reset mid-operation forces all state to reset values immediately. Clear and freeze are not retained.

## Test plan
1. Reset, then write 16'h02A5 to `BASE`+0 → `ledr` = 10'h2A5 one cycle later. Read `BASE`+0 → `rdata` = 16'h02A5.
2. Pulse `inc_br_cnt` 5 cycles and `inc_hit_cnt` 3 cycles, with 2 cycles overlapping `inc_mispr_cnt`. Read +4, +6, +8 → 5, 3, 2. Read +5 → 0.
3. Preload CYC near wrap: force the counter to 32'h0000_FFFF, read +A then +B. → LO = 16'hFFFF and HI = 16'h0000, even though the live counter has since rolled to 32'h0001_0000. Read +A, +B again → 0x0001 (or later) with HI = 16'h0001.
4. Write CTRL = 16'h0002, pulse `inc_br_cnt` 4 times → BR_LO unchanged. Write CTRL = 0, pulse once → BR_LO incremented by 1.
5. Assert `inc_br_cnt` in the same cycle as a CTRL write of 16'h0001 → BR_LO reads 0 next cycle. A read of +C returns 16'h0000.
6. Read unmapped `BASE`+3 → 16'h0000. Assert `rst_n` low mid-count → `ledr`, counters and `rdata` all 0 immediately.

Source files
------------

// File: rtl/mm_periph.sv
// mm_periph: memory-mapped LED/switch/statistics register block.
// Ports: clk, rst_n, addr/wdata/mm_re/mm_we bus, rdata, inc_* pulses, sw, ledr.
module mm_periph #(
  parameter logic [15:0] BASE  = 16'hC000,
  parameter int          LED_W = 10,
  parameter int          SW_W  = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      addr,
  input  logic [15:0]      wdata,
  input  logic             mm_re,
  input  logic             mm_we,
  output logic [15:0]      rdata,
  input  logic             inc_br_cnt,
  input  logic             inc_hit_cnt,
  input  logic             inc_mispr_cnt,
  input  logic [SW_W-1:0]  sw,
  output logic [LED_W-1:0] ledr
);

  // counter index: 0 BR, 1 HIT, 2 MIS, 3 CYC
  logic [31:0]     cnt [4];
  logic [15:0]     shd [4];
  logic [SW_W-1:0] sw_q1;
  logic [SW_W-1:0] sw_q2;
  logic            frz;

  logic       sel;
  logic [3:0] off;
  logic       rd;
  logic       wr;
  logic       ctrl_wr;
  logic       clr;
  logic [3:0] inc;
  logic [3:0] lo_rd;
  logic       unused_ok;

  // block occupies a 16-word aligned window
  assign sel     = (addr[15:4] == BASE[15:4]);
  assign off     = addr[3:0];
  assign rd      = mm_re & sel;
  assign wr      = mm_we & sel;
  assign ctrl_wr = wr & (off == 4'hC);
  assign clr     = ctrl_wr & wdata[0];
  assign inc     = {1'b1, inc_mispr_cnt,
                    inc_hit_cnt, inc_br_cnt};
  assign unused_ok = &{1'b0, wdata};

  always_comb begin
    lo_rd = '0;
    for (int k = 0; k < 4; k++)
      lo_rd[k] = rd && (off == 4'(4 + 2 * k));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ledr  <= '0;
      frz   <= 1'b0;
      sw_q1 <= '0;
      sw_q2 <= '0;
    end else begin
      sw_q1 <= sw;
      sw_q2 <= sw_q1;
      if (wr && off == 4'h0)
        ledr <= wdata[LED_W-1:0];
      if (ctrl_wr)
        frz <= wdata[1];
    end
  end

  // clear beats freeze, freeze beats increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        cnt[k] <= '0;
        shd[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (clr)
          cnt[k] <= '0;
        else if (!frz && inc[k])
          cnt[k] <= cnt[k] + 32'd1;
        // latch upper half so a later HI read
        // pairs with this LO read
        if (lo_rd[k])
          shd[k] <= cnt[k][31:16];
      end
    end
  end

  always_comb begin
    rdata = 16'h0000;
    if (rd) begin
      case (off)
        4'h0: rdata = 16'(ledr);
        4'h1: rdata = 16'(sw_q2);
        4'h4: rdata = cnt[0][15:0];
        4'h5: rdata = shd[0];
        4'h6: rdata = cnt[1][15:0];
        4'h7: rdata = shd[1];
        4'h8: rdata = cnt[2][15:0];
        4'h9: rdata = shd[2];
        4'hA: rdata = cnt[3][15:0];
        4'hB: rdata = shd[3];
        4'hC: rdata = {14'b0, frz, 1'b0};
        default: rdata = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_periph.sv
// tb_mm_periph: directed + random checks of mm_periph
// against a cycle-level register/counter model.
module tb_mm_periph;

  logic        clk;
  logic        rst_n;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        mm_re;
  logic        mm_we;
  logic [15:0] rdata;
  logic        inc_br_cnt;
  logic        inc_hit_cnt;
  logic        inc_mispr_cnt;
  logic [9:0]  sw;
  logic [9:0]  ledr;

  mm_periph dut (
    .clk(clk), .rst_n(rst_n), .addr(addr),
    .wdata(wdata), .mm_re(mm_re), .mm_we(mm_we),
    .rdata(rdata), .inc_br_cnt(inc_br_cnt),
    .inc_hit_cnt(inc_hit_cnt),
    .inc_mispr_cnt(inc_mispr_cnt),
    .sw(sw), .ledr(ledr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model state
  logic [31:0] m_cnt [4];
  logic [15:0] m_shd [4];
  logic [9:0]  m_led;
  logic        m_frz;
  logic [9:0]  swh0, swh1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_cnt[k] = 0;
      m_shd[k] = 0;
    end
    m_led = 0;
    m_frz = 0;
    swh0  = 0;
    swh1  = 0;
  endtask

  function automatic logic [15:0] exp_rd(
      input logic re, input logic [15:0] a);
    int o;
    if (!re || a[15:4] != 12'hC00) return 16'h0;
    o = int'(a[3:0]);
    if (o == 0) return {6'b0, m_led};
    if (o == 1) return {6'b0, swh1};
    if (o >= 4 && o <= 11) begin
      if (o % 2 == 1) return m_shd[(o - 4) / 2];
      return m_cnt[(o - 4) / 2][15:0];
    end
    if (o == 12) return {14'b0, m_frz, 1'b0};
    return 16'h0;
  endfunction

  task automatic model_edge(
      input logic re, input logic we,
      input logic [15:0] a, input logic [15:0] wd,
      input logic b, input logic h, input logic m);
    logic sel;
    int o;
    logic clr;
    logic [3:0] incv;
    sel  = (a[15:4] == 12'hC00);
    o    = int'(a[3:0]);
    incv = {1'b1, m, h, b};
    if (re && sel && o >= 4 && o <= 11 && o % 2 == 0)
      m_shd[(o - 4) / 2] = m_cnt[(o - 4) / 2][31:16];
    clr = we && sel && o == 12 && wd[0];
    for (int k = 0; k < 4; k++) begin
      if (clr) m_cnt[k] = 0;
      else if (!m_frz && incv[k]) m_cnt[k] += 1;
    end
    if (we && sel && o == 0) m_led = wd[9:0];
    if (we && sel && o == 12) m_frz = wd[1];
  endtask

  // one bus cycle; want < 0 means no directed value
  task automatic step(
      input logic re, input logic we,
      input logic [15:0] a, input logic [15:0] wd,
      input logic b, input logic h, input logic m,
      input int want);
    mm_re = re; mm_we = we; addr = a; wdata = wd;
    inc_br_cnt = b; inc_hit_cnt = h;
    inc_mispr_cnt = m;
    #1;
    chk("rdata_model", 32'(rdata), 32'(exp_rd(re, a)));
    chk("ledr_model", 32'(ledr), 32'(m_led));
    if (want >= 0)
      chk("rdata_directed", 32'(rdata), want);
    @(posedge clk);
    model_edge(re, we, a, wd, b, h, m);
    swh1 = swh0;
    swh0 = sw;
    @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] o, input int want);
    step(1, 0, 16'hC000 | 16'(o), 0, 0, 0, 0, want);
  endtask

  task automatic wr(input logic [3:0] o,
                    input logic [15:0] d);
    step(0, 1, 16'hC000 | 16'(o), d, 0, 0, 0, -1);
  endtask

  task automatic idle(input logic b, input logic h,
                      input logic m);
    step(0, 0, 16'h0, 0, b, h, m, -1);
  endtask

  logic [31:0] br0;
  int          guard;

  initial begin
    rst_n = 0; mm_re = 0; mm_we = 0; addr = 0;
    wdata = 0; inc_br_cnt = 0; inc_hit_cnt = 0;
    inc_mispr_cnt = 0; sw = 10'h3C5;
    model_reset();
    #1;
    chk("reset_ledr", 32'(ledr), 0);
    chk("reset_rdata", 32'(rdata), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // LED write/read
    wr(4'h0, 16'h02A5);
    chk("ledr_after_write", 32'(ledr), 32'h2A5);
    rd(4'h0, 16'h02A5);
    rd(4'h1, 16'h03C5);

    // predictor pulses
    idle(1, 1, 1);
    idle(1, 1, 1);
    idle(1, 1, 0);
    idle(1, 0, 0);
    idle(1, 0, 0);
    rd(4'h4, 5);
    rd(4'h6, 3);
    rd(4'h8, 2);
    rd(4'h5, 0);

    // freeze
    wr(4'hC, 16'h0002);
    rd(4'hC, 16'h0002);
    br0 = m_cnt[0];
    repeat (4) idle(1, 0, 0);
    rd(4'h4, int'(br0[15:0]));
    wr(4'hC, 16'h0000);
    idle(1, 0, 0);
    rd(4'h4, int'(br0[15:0]) + 1);

    // clear wins over same-cycle increment
    step(0, 1, 16'hC00C, 16'h0001, 1, 1, 1, -1);
    rd(4'h4, 0);
    rd(4'hC, 0);

    // coherent read across the 16-bit wrap of CYC
    guard = 0;
    while (m_cnt[3] != 32'h0000_FFFF && guard < 70000) begin
      idle(0, 0, 0);
      guard++;
    end
    chk("cyc_reach_timeout", 32'(guard < 70000), 1);
    rd(4'hA, 16'hFFFF);
    rd(4'hB, 16'h0000);
    rd(4'hA, 16'h0001);
    rd(4'hB, 16'h0001);

    // unmapped
    rd(4'h3, 0);
    rd(4'hE, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      logic        re, we;
      if ($urandom_range(0, 3) != 0)
        a = 16'hC000 | 16'($urandom_range(0, 15));
      else
        a = 16'($urandom);
      re = 1'($urandom);
      we = ($urandom_range(0, 5) == 0);
      sw = 10'($urandom);
      step(re, we, a, 16'($urandom),
           1'($urandom), 1'($urandom),
           1'($urandom), -1);
    end

    // async reset mid-count
    wr(4'h0, 16'h0155);
    mm_re = 1; addr = 16'hC000;
    inc_br_cnt = 1;
    #2 rst_n = 0;
    #1;
    chk("rst_ledr", 32'(ledr), 0);
    chk("rst_rdata", 32'(rdata), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    rd(4'h4, 0);
    rd(4'hA, 1);
    rd(4'hC, 0);
    rd(4'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
